// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store bus controller between the memory stage and data memory.
// Builds byte-lane enables and replicated store data, runs a req/ack handshake,
// stalls the core until the transfer retires, and hands the raw read word plus
// the latched address bits A1A0 to the downstream load-alignment stage.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   defined   : misaligned lh/sh (A0=1) and lw/sw (A1A0!=0) fault without a bus cycle
//   undefined : no alignment check; sh uses A1 only, lw/sw use the word address
//
// Parameters
//   AW           byte-address width
//   TIMEOUT_CYC  cycles in REQ without bus_ack before the access is aborted (>=1)
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   core_rd, core_wr        load / store request, held by core while stall=1
//   lb, lh, lw              load size, one-hot, qualified by core_rd
//   sb, sh, sw              store size, one-hot, qualified by core_wr
//   addr, wdata             byte address, right-justified store data
//   stall                   core must hold its state this cycle
//   rdata_word, a1a0        raw memory word and latched addr[1:0]
//   rdata_valid             one-cycle pulse, load data valid
//   err                     one-cycle pulse, access faulted
//   bus_req/we/addr/be/wdata memory request side
//   bus_rdata, bus_ack      memory response side

module data_mem_ctrl #(
    parameter int AW          = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          core_rd,
    input  logic          core_wr,
    input  logic          lb,
    input  logic          lh,
    input  logic          lw,
    input  logic          sb,
    input  logic          sh,
    input  logic          sw,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic          stall,
    output logic [31:0]   rdata_word,
    output logic [1:0]    a1a0,
    output logic          rdata_valid,
    output logic          err,
    output logic          bus_req,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [3:0]    bus_be,
    output logic [31:0]   bus_wdata,
    input  logic [31:0]   bus_rdata,
    input  logic          bus_ack
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic          ld_q, ld_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wd_q, wd_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        req_any;
    logic        req_one;
    logic        req_both;
    logic        misal;
    logic        fault;
    logic [3:0]  be_new;
    logic [31:0] wd_new;

    // Load size only matters downstream; loads always fetch the whole word.
    logic unused_sz;
    assign unused_sz = ^{lb, lh, lw};

    assign req_any  = core_rd | core_wr;
    assign req_one  = core_rd ^ core_wr;
    assign req_both = core_rd & core_wr;

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misal = 1'b0;
        if (core_rd) begin
            misal = (lh & addr[0]) | (lw & (addr[1:0] != 2'b00));
        end
        if (core_wr) begin
            misal = (sh & addr[0]) | (sw & (addr[1:0] != 2'b00));
        end
    end
`else
    assign misal = 1'b0;
`endif

    // Both request lines at once is a core bug; fault it without touching the bus.
    assign fault = req_both | (req_one & misal);

    // Store lane steering; loads read the full word.
    always_comb begin
        be_new = 4'b1111;
        wd_new = 32'h0;
        if (core_wr) begin
            unique case (1'b1)
                sb: begin
                    be_new = 4'b0001 << addr[1:0];
                    wd_new = {4{wdata[7:0]}};
                end
                sh: begin
                    be_new = addr[1] ? 4'b1100 : 4'b0011;
                    wd_new = {2{wdata[15:0]}};
                end
                sw: begin
                    be_new = 4'b1111;
                    wd_new = wdata;
                end
                default: begin
                    be_new = 4'b1111;
                    wd_new = wdata;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (fault) begin
                    state_d = DONE;
                end else if (req_one) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                // ack wins over a coincident timeout
                if (bus_ack || (cnt_q == CNT_LAST)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Access context and response capture
    always_comb begin
        addr_d  = addr_q;
        we_d    = we_q;
        ld_d    = ld_q;
        be_d    = be_q;
        wd_d    = wd_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    addr_d = addr;
                    we_d   = core_wr;
                    ld_d   = core_rd & ~core_wr;
                    be_d   = be_new;
                    wd_d   = wd_new;
                    err_d  = fault;
                    cnt_d  = '0;
                    if (fault) begin
                        rdata_d = 32'h0;
                    end
                end
            end
            REQ: begin
                if (bus_ack) begin
                    err_d = 1'b0;
                    if (ld_q) begin
                        rdata_d = bus_rdata;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end else begin
                    // only reached below CNT_LAST, so it never wraps
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            ld_q    <= 1'b0;
            be_q    <= 4'b0000;
            wd_q    <= 32'h0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            cnt_q   <= '0;
        end else begin
            addr_q  <= addr_d;
            we_q    <= we_d;
            ld_q    <= ld_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs; bus side is quiet outside REQ so reset drops it immediately.
    always_comb begin
        stall       = 1'b0;
        bus_req     = 1'b0;
        bus_we      = 1'b0;
        bus_addr    = '0;
        bus_be      = 4'b0000;
        bus_wdata   = 32'h0;
        rdata_valid = 1'b0;
        err         = 1'b0;
        rdata_word  = rdata_q;
        a1a0        = addr_q[1:0];
        unique case (state_q)
            IDLE: begin
                stall = req_any;
            end
            REQ: begin
                stall     = 1'b1;
                bus_req   = 1'b1;
                bus_we    = we_q;
                bus_addr  = {addr_q[AW-1:2], 2'b00};
                bus_be    = be_q;
                bus_wdata = wd_q;
            end
            DONE: begin
                rdata_valid = ld_q & ~err_q;
                err         = err_q;
            end
            default: begin
            end
        endcase
    end

endmodule
